// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the mem_arbiter block: sequencer states,
// default RAM geometry and rw encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 8;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational rotating-priority picker: returns the first requester at or
// after ptr_i, wrapping modulo N (N need not be a power of two).
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] index_o
);

  localparam logic [IW:0] NUM = (IW+1)'(N);

  logic [2*N-1:0] reqDbl;
  logic [N-1:0]   reqRot;
  logic [IW-1:0]  offset;
  logic [IW:0]    sum;

  // Doubling the vector lets a plain shift perform the rotation.
  assign reqDbl  = {req_i, req_i};
  assign reqRot  = N'(reqDbl >> ptr_i);
  assign valid_o = |reqRot;

  always_comb begin
    offset = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (reqRot[k]) offset = IW'(k);
    end
  end

  assign sum     = {1'b0, ptr_i} + {1'b0, offset};
  assign index_o = (sum >= NUM) ? IW'(sum - NUM) : sum[IW-1:0];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer giving NUM_CORES requesters one transaction at a time
// on a shared synchronous RAM. Optional bus locking: define MEM_ARB_LOCK_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CORES    = 4,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        core_request,
  input  logic [NUM_CORES-1:0]        core_rw,
  input  logic [NUM_CORES-1:0]        core_lock,
  input  logic [NUM_CORES*ADDR_W-1:0] core_address,
  input  logic [NUM_CORES*DATA_W-1:0] core_data_in,
  output logic [NUM_CORES*DATA_W-1:0] core_data_out,
  output logic [NUM_CORES-1:0]        core_grant,
  output logic                        busy,
  output logic [ADDR_W-1:0]           RAM_address,
  output logic [DATA_W-1:0]           RAM_data_in,
  input  logic [DATA_W-1:0]           RAM_data_out,
  output logic                        ram_rw
);

  localparam int IW = $clog2(NUM_CORES);
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam logic [IW-1:0] LAST_CORE = IW'(NUM_CORES - 1);

  state_e                      state_q, state_d;
  logic [IW-1:0]               rrPtr_q, rrPtr_d;
  logic [IW-1:0]               owner_q, owner_d;
  logic [NUM_CORES-1:0]        grant_q, grant_d;
  logic                        ramRw_q, ramRw_d;
  logic [ADDR_W-1:0]           ramAddr_q, ramAddr_d;
  logic [DATA_W-1:0]           ramDin_q, ramDin_d;
  logic [NUM_CORES*DATA_W-1:0] dataOut_q, dataOut_d;
  logic [LW-1:0]               latCnt_q, latCnt_d;

  logic [NUM_CORES-1:0] pickReq;
  logic [IW-1:0]        pickPtr;
  logic [IW-1:0]        winIdx;
  logic                 winValid;
  logic [ADDR_W-1:0]    selAddr;
  logic [DATA_W-1:0]    selData;
  logic                 selRw;
  logic [IW-1:0]        ownerNext;

  assign ownerNext = (owner_q == LAST_CORE) ? '0 : owner_q + IW'(1);

`ifdef MEM_ARB_LOCK_EN
  logic lockFlag_q, lockFlag_d;
  logic ownerLock;

  always_comb begin
    ownerLock = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (owner_q == IW'(i)) ownerLock = core_lock[i];
    end
  end

  // While locked, only the owner may win and the search starts at the owner.
  assign pickReq = lockFlag_q ? (core_request & (NUM_CORES'(1) << owner_q)) : core_request;
  assign pickPtr = lockFlag_q ? owner_q : rrPtr_q;
`else
  logic unusedLock;
  assign unusedLock = ^core_lock;
  assign pickReq    = core_request;
  assign pickPtr    = rrPtr_q;
`endif

  rr_picker #(
    .N  (NUM_CORES),
    .IW (IW)
  ) u_picker (
    .req_i   (pickReq),
    .ptr_i   (pickPtr),
    .valid_o (winValid),
    .index_o (winIdx)
  );

  always_comb begin
    selAddr = '0;
    selData = '0;
    selRw   = RW_READ;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (winIdx == IW'(i)) begin
        selAddr = core_address[i*ADDR_W +: ADDR_W];
        selData = core_data_in[i*DATA_W +: DATA_W];
        selRw   = core_rw[i];
      end
    end
  end

  // Grant and the write strobe default low so each is a single-cycle pulse.
  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    owner_d   = owner_q;
    grant_d   = '0;
    ramRw_d   = 1'b0;
    ramAddr_d = ramAddr_q;
    ramDin_d  = ramDin_q;
    dataOut_d = dataOut_q;
    latCnt_d  = latCnt_q;
`ifdef MEM_ARB_LOCK_EN
    lockFlag_d = lockFlag_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef MEM_ARB_LOCK_EN
        if (lockFlag_q && !ownerLock) begin
          lockFlag_d = 1'b0;
          rrPtr_d    = ownerNext;
        end else
`endif
        if (winValid) begin
          owner_d   = winIdx;
          ramAddr_d = selAddr;
          ramDin_d  = selData;
          if (selRw == RW_WRITE) begin
            ramRw_d = RW_WRITE;
            state_d = WR;
          end else begin
            latCnt_d = LW'(READ_LATENCY);
            state_d  = RD;
          end
        end
      end
      WR: begin
        grant_d = NUM_CORES'(1) << owner_q;
        state_d = DONE;
      end
      RD: begin
        if (latCnt_q == '0) begin
          for (int i = 0; i < NUM_CORES; i++) begin
            if (owner_q == IW'(i)) dataOut_d[i*DATA_W +: DATA_W] = RAM_data_out;
          end
          grant_d = NUM_CORES'(1) << owner_q;
          state_d = DONE;
        end else begin
          latCnt_d = latCnt_q - LW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef MEM_ARB_LOCK_EN
        if (ownerLock) begin
          lockFlag_d = 1'b1;
        end else begin
          lockFlag_d = 1'b0;
          rrPtr_d    = ownerNext;
        end
`else
        rrPtr_d = ownerNext;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rrPtr_q   <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      ramRw_q   <= 1'b0;
      ramAddr_q <= '0;
      ramDin_q  <= '0;
      dataOut_q <= '0;
      latCnt_q  <= '0;
`ifdef MEM_ARB_LOCK_EN
      lockFlag_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      ramRw_q   <= ramRw_d;
      ramAddr_q <= ramAddr_d;
      ramDin_q  <= ramDin_d;
      dataOut_q <= dataOut_d;
      latCnt_q  <= latCnt_d;
`ifdef MEM_ARB_LOCK_EN
      lockFlag_q <= lockFlag_d;
`endif
    end
  end

  assign core_grant    = grant_q;
  assign busy          = (state_q != IDLE);
  assign ram_rw        = ramRw_q;
  assign RAM_address   = ramAddr_q;
  assign RAM_data_in   = ramDin_q;
  assign core_data_out = dataOut_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a latency-1 instance with a RAM model and
// a latency-3 instance for read-timing checks. Lock test runs with MEM_ARB_LOCK_EN.
module tb_mem_arbiter;

  localparam int NC = 4;
  localparam int AW = 9;
  localparam int DW = 8;

  typedef struct {
    logic [1:0] core;
    logic       isRead;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NC-1:0]    req, rw, lock;
  logic [AW-1:0]    addrArr [NC];
  logic [DW-1:0]    dinArr  [NC];
  wire  [NC*AW-1:0] addrPk;
  wire  [NC*DW-1:0] dinPk;
  wire  [NC*DW-1:0] doutPk;
  wire  [DW-1:0]    doutArr [NC];
  wire  [NC-1:0]    grant;
  wire              busy, ramRw;
  wire  [AW-1:0]    ramAddr;
  wire  [DW-1:0]    ramDin, ramDout;

  for (genvar g = 0; g < NC; g++) begin : g_pack
    assign addrPk[g*AW +: AW] = addrArr[g];
    assign dinPk[g*DW +: DW]  = dinArr[g];
    assign doutArr[g]         = doutPk[g*DW +: DW];
  end

  mem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .core_request(req), .core_rw(rw), .core_lock(lock),
    .core_address(addrPk), .core_data_in(dinPk), .core_data_out(doutPk),
    .core_grant(grant), .busy(busy), .RAM_address(ramAddr), .RAM_data_in(ramDin),
    .RAM_data_out(ramDout), .ram_rw(ramRw)
  );

  logic [NC-1:0]    req3, rw3, lock3;
  logic [NC*AW-1:0] addrPk3;
  logic [NC*DW-1:0] dinPk3;
  wire  [NC*DW-1:0] doutPk3;
  wire  [NC-1:0]    grant3;
  wire              busy3, ramRw3;
  wire  [AW-1:0]    ramAddr3;
  wire  [DW-1:0]    ramDin3, ramDout3;

  mem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .core_request(req3), .core_rw(rw3), .core_lock(lock3),
    .core_address(addrPk3), .core_data_in(dinPk3), .core_data_out(doutPk3),
    .core_grant(grant3), .busy(busy3), .RAM_address(ramAddr3), .RAM_data_in(ramDin3),
    .RAM_data_out(ramDout3), .ram_rw(ramRw3)
  );

  function automatic logic [7:0] initVal(input logic [8:0] a);
    return a[7:0] ^ {7'b0, a[8]} ^ 8'h5A;
  endfunction

  // Latency-1 RAM, reloaded with the initVal pattern while reset is high.
  logic [7:0] mem [512];
  logic [7:0] ramQ;
  always @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < 512; a++) mem[a] <= initVal(9'(a));
    end else if (ramRw) begin
      mem[ramAddr] <= ramDin;
    end
    ramQ <= mem[ramAddr];
  end
  assign ramDout = ramQ;

  logic [7:0] p1, p2, p3;
  always @(posedge clk) begin
    p1 <= initVal(ramAddr3) ^ 8'h66;
    p2 <= p1;
    p3 <= p2;
  end
  assign ramDout3 = p3;

  task automatic applyStimulus(input logic [1:0] core, input logic r, input logic w,
                               input logic [8:0] a, input logic [7:0] d);
    req[core]     = r;
    rw[core]      = w;
    addrArr[core] = a;
    dinArr[core]  = d;
  endtask

  task automatic waitGrant(input int budget, output logic [3:0] g, output int at);
    g  = '0;
    at = -1;
    for (int k = 0; k < budget && at < 0; k++) begin
      @(negedge clk);
      if (grant !== 4'b0) begin
        g  = grant;
        at = cyc;
      end
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    req = '0; rw = '0; lock = '0;
    req3 = '0; rw3 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    compared += 7;
    if (grant !== 4'b0) begin mismatched++; $display("[TB] FAIL reset_grant: got %b want 0000", grant); end
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    if (ramRw !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ram_rw: got %b want 0", ramRw); end
    if (ramAddr !== 9'h0) begin mismatched++; $display("[TB] FAIL reset_ram_addr: got %h want 000", ramAddr); end
    if (ramDin !== 8'h0) begin mismatched++; $display("[TB] FAIL reset_ram_din: got %h want 00", ramDin); end
    if (doutPk !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_data_out: got %h want 0", doutPk); end
    if (busy3 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy3: got %b want 0", busy3); end
    reset = 1'b0;
  endtask

  task automatic test_write();
    exp_t e;
    logic [3:0] g = '0;
    int gAt = -1, rwHigh = 0, gHigh = 0;
    applyStimulus(2'd2, 1'b1, 1'b1, 9'h1F0, 8'hA5);
    sb.push_back('{2'd2, 1'b0, 8'h00, cyc + 2});
    @(negedge clk);
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL write_busy: got %b want 1", busy); end
    applyStimulus(2'd2, 1'b0, 1'b0, 9'h0AA, 8'h11);
    for (int k = 0; k < 6; k++) begin
      if (ramRw === 1'b1) begin
        rwHigh++;
        compared += 2;
        if (ramAddr !== 9'h1F0) begin mismatched++; $display("[TB] FAIL write_addr: got %h want 1f0", ramAddr); end
        if (ramDin !== 8'hA5) begin mismatched++; $display("[TB] FAIL write_data: got %h want a5", ramDin); end
      end
      if (grant !== 4'b0) begin
        gHigh++;
        if (gAt < 0) begin g = grant; gAt = cyc; end
      end
      @(negedge clk);
    end
    e = sb.pop_front();
    compared += 5;
    if (rwHigh != 1) begin mismatched++; $display("[TB] FAIL write_strobe_len: got %0d want 1", rwHigh); end
    if (gHigh != 1) begin mismatched++; $display("[TB] FAIL write_grant_len: got %0d want 1", gHigh); end
    if (g !== (4'b0001 << e.core)) begin mismatched++; $display("[TB] FAIL write_grant: got %b want %b", g, 4'b0001 << e.core); end
    if (gAt != e.due) begin mismatched++; $display("[TB] FAIL write_grant_time: got %0d want %0d", gAt, e.due); end
    if (doutArr[2] !== 8'h00) begin mismatched++; $display("[TB] FAIL write_no_dout: got %h want 00", doutArr[2]); end
  endtask

  task automatic test_read();
    exp_t e;
    logic [3:0] g;
    int gAt;
    applyStimulus(2'd1, 1'b1, 1'b0, 9'h1F0, 8'h00);
    sb.push_back('{2'd1, 1'b1, 8'hA5, cyc + 3});
    @(negedge clk);
    applyStimulus(2'd1, 1'b0, 1'b0, 9'h000, 8'h00);
    waitGrant(10, g, gAt);
    e = sb.pop_front();
    compared += 3;
    if (g !== (4'b0001 << e.core)) begin mismatched++; $display("[TB] FAIL read_grant: got %b want %b", g, 4'b0001 << e.core); end
    if (gAt != e.due) begin mismatched++; $display("[TB] FAIL read_grant_time: got %0d want %0d", gAt, e.due); end
    if (doutArr[e.core] !== e.data) begin mismatched++; $display("[TB] FAIL read_data: got %h want %h", doutArr[e.core], e.data); end
    @(negedge clk);
    compared++;
    if (grant !== 4'b0) begin mismatched++; $display("[TB] FAIL read_grant_drop: got %b want 0000", grant); end
  endtask

  task automatic test_all_cores();
    exp_t e;
    logic [3:0] g;
    int gAt, c0;
    doReset();
    for (int c = 0; c < NC; c++) applyStimulus(2'(c), 1'b1, 1'b0, 9'(9'h040 + c), 8'h00);
    c0 = cyc + 1;
    for (int k = 0; k < NC; k++) sb.push_back('{2'(k), 1'b1, initVal(9'(9'h040 + k)), c0 + 2 + 4 * k});
    for (int k = 0; k < NC; k++) begin
      waitGrant(12, g, gAt);
      e = sb.pop_front();
      compared += 3;
      if (g !== (4'b0001 << e.core)) begin mismatched++; $display("[TB] FAIL all_grant%0d: got %b want %b", k, g, 4'b0001 << e.core); end
      if (gAt != e.due) begin mismatched++; $display("[TB] FAIL all_time%0d: got %0d want %0d", k, gAt, e.due); end
      if (doutArr[e.core] !== e.data) begin mismatched++; $display("[TB] FAIL all_data%0d: got %h want %h", k, doutArr[e.core], e.data); end
      applyStimulus(e.core, 1'b0, 1'b0, 9'h000, 8'h00);
    end
    @(negedge clk);
  endtask

  task automatic test_hold_two();
    exp_t e;
    logic [3:0] g;
    int gAt, c0;
    applyStimulus(2'd0, 1'b1, 1'b0, 9'h050, 8'h00);
    applyStimulus(2'd3, 1'b1, 1'b0, 9'h053, 8'h00);
    c0 = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) sb.push_back('{2'd0, 1'b1, initVal(9'h050), c0 + 2 + 4 * k});
      else            sb.push_back('{2'd3, 1'b1, initVal(9'h053), c0 + 2 + 4 * k});
    end
    for (int k = 0; k < 4; k++) begin
      waitGrant(12, g, gAt);
      e = sb.pop_front();
      compared += 2;
      if (g !== (4'b0001 << e.core)) begin mismatched++; $display("[TB] FAIL hold_grant%0d: got %b want %b", k, g, 4'b0001 << e.core); end
      if (gAt != e.due) begin mismatched++; $display("[TB] FAIL hold_time%0d: got %0d want %0d", k, gAt, e.due); end
    end
    applyStimulus(2'd0, 1'b0, 1'b0, 9'h000, 8'h00);
    applyStimulus(2'd3, 1'b0, 1'b0, 9'h000, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    exp_t e;
    logic [3:0] g;
    int gAt, stray = 0;
    applyStimulus(2'd2, 1'b1, 1'b0, 9'h061, 8'h00);
    @(negedge clk);
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_busy_before: got %b want 1", busy); end
    applyStimulus(2'd2, 1'b0, 1'b0, 9'h000, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    compared += 4;
    if (grant !== 4'b0) begin mismatched++; $display("[TB] FAIL abort_grant: got %b want 0000", grant); end
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    if (ramRw !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_ram_rw: got %b want 0", ramRw); end
    if (doutArr[2] !== 8'h00) begin mismatched++; $display("[TB] FAIL abort_dout: got %h want 00", doutArr[2]); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (grant !== 4'b0) stray++;
    end
    compared++;
    if (stray != 0) begin mismatched++; $display("[TB] FAIL abort_stray_grant: got %0d want 0", stray); end
    applyStimulus(2'd2, 1'b1, 1'b0, 9'h061, 8'h00);
    sb.push_back('{2'd2, 1'b1, initVal(9'h061), cyc + 3});
    @(negedge clk);
    applyStimulus(2'd2, 1'b0, 1'b0, 9'h000, 8'h00);
    waitGrant(10, g, gAt);
    e = sb.pop_front();
    compared += 3;
    if (g !== (4'b0001 << e.core)) begin mismatched++; $display("[TB] FAIL fresh_grant: got %b want %b", g, 4'b0001 << e.core); end
    if (gAt != e.due) begin mismatched++; $display("[TB] FAIL fresh_time: got %0d want %0d", gAt, e.due); end
    if (doutArr[e.core] !== e.data) begin mismatched++; $display("[TB] FAIL fresh_data: got %h want %h", doutArr[e.core], e.data); end
    @(negedge clk);
  endtask

  task automatic test_read_latency3();
    exp_t e;
    logic [3:0] g = '0;
    int gAt = -1;
    req3[1] = 1'b1;
    rw3[1]  = 1'b0;
    addrPk3[17:9] = 9'h0A5;
    sb.push_back('{2'd1, 1'b1, initVal(9'h0A5) ^ 8'h66, cyc + 5});
    @(negedge clk);
    req3[1] = 1'b0;
    addrPk3[17:9] = 9'h000;
    for (int k = 0; k < 12 && gAt < 0; k++) begin
      @(negedge clk);
      if (grant3 !== 4'b0) begin g = grant3; gAt = cyc; end
    end
    e = sb.pop_front();
    compared += 3;
    if (g !== (4'b0001 << e.core)) begin mismatched++; $display("[TB] FAIL lat3_grant: got %b want %b", g, 4'b0001 << e.core); end
    if (gAt != e.due) begin mismatched++; $display("[TB] FAIL lat3_time: got %0d want %0d", gAt, e.due); end
    if (doutPk3[15:8] !== e.data) begin mismatched++; $display("[TB] FAIL lat3_data: got %h want %h", doutPk3[15:8], e.data); end
    repeat (2) @(negedge clk);
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic test_lock();
    exp_t e;
    logic [3:0] g;
    int gAt, c0;
    doReset();
    lock[1] = 1'b1;
    applyStimulus(2'd1, 1'b1, 1'b0, 9'h071, 8'h00);
    applyStimulus(2'd2, 1'b1, 1'b0, 9'h072, 8'h00);
    c0 = cyc + 1;
    sb.push_back('{2'd1, 1'b1, initVal(9'h071), c0 + 2});
    sb.push_back('{2'd1, 1'b1, initVal(9'h071), c0 + 6});
    sb.push_back('{2'd2, 1'b1, initVal(9'h072), c0 + 10});
    for (int k = 0; k < 3; k++) begin
      waitGrant(12, g, gAt);
      e = sb.pop_front();
      compared += 3;
      if (g !== (4'b0001 << e.core)) begin mismatched++; $display("[TB] FAIL lock_grant%0d: got %b want %b", k, g, 4'b0001 << e.core); end
      if (gAt != e.due) begin mismatched++; $display("[TB] FAIL lock_time%0d: got %0d want %0d", k, gAt, e.due); end
      if (doutArr[e.core] !== e.data) begin mismatched++; $display("[TB] FAIL lock_data%0d: got %h want %h", k, doutArr[e.core], e.data); end
      if (k == 1) begin
        lock[1] = 1'b0;
        applyStimulus(2'd1, 1'b0, 1'b0, 9'h000, 8'h00);
      end
      if (k == 2) applyStimulus(2'd2, 1'b0, 1'b0, 9'h000, 8'h00);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    reset   = 1'b1;
    req     = '0;
    rw      = '0;
    lock    = '0;
    addrArr = '{default: '0};
    dinArr  = '{default: '0};
    req3    = '0;
    rw3     = '0;
    lock3   = '0;
    addrPk3 = '0;
    dinPk3  = '0;
    test_reset();
    test_write();
    test_read();
    test_all_cores();
    test_hold_two();
    test_reset_mid_read();
    test_read_latency3();
`ifdef MEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
